// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX AXI-Stream frame arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StDrain
  } arb_state_e;

  localparam int unsigned DefMaxBeats = 375;

  function automatic int unsigned cnt_width(input int unsigned max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_select #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_axis_frame_arbiter.sv
// Frame-level round-robin AXI-Stream arbiter for the TX MAC with length limit and pause hold-off.
// Optional per-port frame / truncation counters when TX_ARB_STATS_EN is defined.
module tx_axis_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 3,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int unsigned MAX_BEATS       = DefMaxBeats
) (
  input  logic                                 tx_clk,
  input  logic                                 tx_rst,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] in_s_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] in_s_tkeep,
  input  logic [NUM_PORTS-1:0]                 in_s_tvalid,
  input  logic [NUM_PORTS-1:0]                 in_s_tlast,
  output logic [NUM_PORTS-1:0]                 out_s_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           out_m_tdata,
  output logic [AXIS_DATA_BYTES-1:0]           out_m_tkeep,
  output logic                                 out_m_tvalid,
  output logic                                 out_m_tlast,
  input  logic                                 in_m_tready,
  input  logic                                 in_tx_pause,
  output logic [NUM_PORTS-1:0]                 out_grant,
  output logic                                 out_trunc_err
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]              out_frame_cnt,
  output logic [15:0]                          out_trunc_cnt
`endif
);

  localparam int unsigned PtrW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW = cnt_width(MAX_BEATS);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BEATS - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PtrW-1:0]      gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, sel_idx;
  logic [CntW-1:0]      beat_cnt_q, beat_cnt_d;
  logic                 trunc_err_q, trunc_err_d;
  logic [NUM_PORTS-1:0] sel_grant;
  logic                 sel_found;
  logic                 src_valid, src_last, at_limit, frame_done, trunc_hit;

  logic [AXIS_DATA_WIDTH-1:0] tdata_arr [NUM_PORTS];
  logic [AXIS_DATA_BYTES-1:0] tkeep_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign tdata_arr[p] = in_s_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign tkeep_arr[p] = in_s_tkeep[p*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
  end

  rr_select #(
    .NUM_REQ (NUM_PORTS),
    .PTR_W   (PtrW)
  ) u_rr_select (
    .req   (in_s_tvalid),
    .ptr   (rr_ptr_q),
    .grant (sel_grant),
    .found (sel_found)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (sel_grant[i]) sel_idx = PtrW'(i);
    end
  end

  assign src_valid = in_s_tvalid[gidx_q];
  assign src_last  = in_s_tlast[gidx_q];
  assign at_limit  = (beat_cnt_q == LastCnt);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    trunc_err_d  = 1'b0;
    frame_done   = 1'b0;
    trunc_hit    = 1'b0;
    out_s_tready = '0;
    out_m_tdata  = '0;
    out_m_tkeep  = '0;
    out_m_tvalid = 1'b0;
    out_m_tlast  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Grant is registered here; the first beat moves in the following cycle.
        if (!in_tx_pause && sel_found) begin
          state_d    = StFwd;
          grant_d    = sel_grant;
          gidx_d     = sel_idx;
          beat_cnt_d = '0;
        end
      end
      StFwd: begin
        out_s_tready[gidx_q] = in_m_tready;
        out_m_tdata          = tdata_arr[gidx_q];
        out_m_tkeep          = tkeep_arr[gidx_q];
        out_m_tvalid         = src_valid;
        out_m_tlast          = src_last | at_limit;
        if (src_valid && in_m_tready) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (src_last) begin
            frame_done = 1'b1;
          end else if (at_limit) begin
            trunc_hit   = 1'b1;
            trunc_err_d = 1'b1;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        out_s_tready[gidx_q] = 1'b1;
        if (src_valid && src_last) frame_done = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (frame_done) begin
      state_d    = StIdle;
      grant_d    = '0;
      beat_cnt_d = '0;
      rr_ptr_d   = PtrW'((int'(gidx_q) + 1) % NUM_PORTS);
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign out_grant     = grant_q;
  assign out_trunc_err = trunc_err_q;

`ifdef TX_ARB_STATS_EN
  logic [15:0] frame_cnt_q [NUM_PORTS];
  logic [15:0] trunc_cnt_q;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) frame_cnt_q[p] <= '0;
      trunc_cnt_q <= '0;
    end else begin
      if (frame_done) frame_cnt_q[gidx_q] <= frame_cnt_q[gidx_q] + 16'd1;
      if (trunc_hit) trunc_cnt_q <= trunc_cnt_q + 16'd1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stats
    assign out_frame_cnt[p*16 +: 16] = frame_cnt_q[p];
  end
  assign out_trunc_cnt = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_tx_axis_frame_arbiter.sv
// Directed self-checking bench for tx_axis_frame_arbiter (3 ports, 32-bit, 375-beat limit).
module tb_tx_axis_frame_arbiter;

  localparam int NP = 3;

  logic            tx_clk = 1'b0;
  logic            tx_rst = 1'b1;
  logic [NP*32-1:0] in_s_tdata = '0;
  logic [NP*4-1:0] in_s_tkeep = '0;
  logic [NP-1:0]   in_s_tvalid = '0;
  logic [NP-1:0]   in_s_tlast = '0;
  logic [NP-1:0]   out_s_tready;
  logic [31:0]     out_m_tdata;
  logic [3:0]      out_m_tkeep;
  logic            out_m_tvalid;
  logic            out_m_tlast;
  logic            in_m_tready = 1'b0;
  logic            in_tx_pause = 1'b0;
  logic [NP-1:0]   out_grant;
  logic            out_trunc_err;
`ifdef TX_ARB_STATS_EN
  logic [NP*16-1:0] out_frame_cnt;
  logic [15:0]      out_trunc_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Source model: per port, frames left, beats per frame, current beat, frames sent
  int src_left [NP];
  int src_len  [NP];
  int src_beat [NP];
  int src_fr   [NP];
  logic mt_ready = 1'b1;
  logic pause = 1'b0;

  always #5 tx_clk = ~tx_clk;

  tx_axis_frame_arbiter dut (
    .tx_clk        (tx_clk),
    .tx_rst        (tx_rst),
    .in_s_tdata    (in_s_tdata),
    .in_s_tkeep    (in_s_tkeep),
    .in_s_tvalid   (in_s_tvalid),
    .in_s_tlast    (in_s_tlast),
    .out_s_tready  (out_s_tready),
    .out_m_tdata   (out_m_tdata),
    .out_m_tkeep   (out_m_tkeep),
    .out_m_tvalid  (out_m_tvalid),
    .out_m_tlast   (out_m_tlast),
    .in_m_tready   (in_m_tready),
    .in_tx_pause   (in_tx_pause),
    .out_grant     (out_grant),
`ifdef TX_ARB_STATS_EN
    .out_trunc_err (out_trunc_err),
    .out_frame_cnt (out_frame_cnt),
    .out_trunc_cnt (out_trunc_cnt)
`else
    .out_trunc_err (out_trunc_err)
`endif
  );

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      src_left[p] = 0; src_len[p] = 1; src_beat[p] = 0; src_fr[p] = 0;
    end
    mt_ready = 1'b1;
    pause    = 1'b0;
  endtask

  task automatic do_reset();
    clear_src();
    tx_rst = 1'b1;
    in_s_tvalid = '0;
    in_s_tlast  = '0;
    repeat (2) @(negedge tx_clk);
    tx_rst = 1'b0;
  endtask

  // One clock cycle: drive sources at negedge, outputs settle, then advance accepted beats.
  task automatic step();
    @(negedge tx_clk);
    for (int p = 0; p < NP; p++) begin
      in_s_tvalid[p] = (src_left[p] > 0);
      in_s_tlast[p]  = (src_beat[p] == src_len[p] - 1);
      in_s_tdata[p*32 +: 32] = {8'(p), 8'(src_fr[p]), 16'(src_beat[p])};
      in_s_tkeep[p*4 +: 4] = in_s_tlast[p] ? 4'h3 : 4'hF;
    end
    in_m_tready = mt_ready;
    in_tx_pause = pause;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (in_s_tvalid[p] && out_s_tready[p]) begin
        if (in_s_tlast[p]) begin
          src_beat[p] = 0; src_left[p]--; src_fr[p]++;
        end else begin
          src_beat[p]++;
        end
      end
    end
  endtask

  task automatic test_reset();
    tx_rst = 1'b1;
    #2;
    checks++;
    if ({out_grant, out_m_tvalid, out_m_tlast, out_trunc_err, out_s_tready} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b valid=%b last=%b trunc=%b ready=%b want all 0",
               out_grant, out_m_tvalid, out_m_tlast, out_trunc_err, out_s_tready);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [40:0] exp;
    do_reset();
    for (int p = 0; p < NP; p++) begin src_left[p] = 2; src_len[p] = 4; end
    for (int f = 0; f < 4; f++) begin
      int p = f % 3;
      step();
      checks++;
      if (out_grant !== 3'b000 || out_m_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL rr_gap f=%0d got grant=%b valid=%b want 000/0", f, out_grant, out_m_tvalid);
      end
      for (int b = 0; b < 4; b++) begin
        step();
        exp = {3'(1 << p), 1'b1, b == 3, (b == 3) ? 4'h3 : 4'hF, 8'(p), 8'(f / 3), 16'(b)};
        checks++;
        if ({out_grant, out_m_tvalid, out_m_tlast, out_m_tkeep, out_m_tdata} !== exp) begin
          failures++;
          $display("FAIL rr_beat f=%0d b=%0d got %h want %h", f, b,
                   {out_grant, out_m_tvalid, out_m_tlast, out_m_tkeep, out_m_tdata}, exp);
        end
      end
    end
  endtask

  task automatic test_ready_toggle();
    int exp_beat [8] = '{0, 0, 0, 1, 1, 2, 2, 0};
    do_reset();
    src_left[1] = 1; src_len[1] = 3;
    for (int c = 0; c < 8; c++) begin
      mt_ready = (c % 2 == 0);
      step();
      if (c >= 1 && c <= 6) begin
        checks++;
        if (out_grant !== 3'b010 || out_m_tvalid !== 1'b1 ||
            out_m_tdata !== {8'd1, 8'd0, 16'(exp_beat[c])} || out_m_tlast !== (c >= 5) ||
            out_s_tready !== {1'b0, mt_ready, 1'b0}) begin
          failures++;
          $display("FAIL ready_toggle c=%0d got grant=%b data=%h last=%b ready=%b want beat %0d",
                   c, out_grant, out_m_tdata, out_m_tlast, out_s_tready, exp_beat[c]);
        end
      end else if (c == 7) begin
        checks++;
        if (out_grant !== 3'b000) begin
          failures++;
          $display("FAIL ready_toggle_end got grant=%b want 000", out_grant);
        end
      end
    end
  endtask

  task automatic test_truncation();
    int n_trunc = 0, trunc_cyc = -1, bad_fwd = 0, bad_drain = 0, bad_other = 0;
    do_reset();
    src_left[0] = 1; src_len[0] = 400;
    src_left[1] = 1; src_len[1] = 2;
    for (int c = 0; c <= 402; c++) begin
      step();
      if (out_trunc_err === 1'b1) begin n_trunc++; trunc_cyc = c; end
      if (c >= 1 && c <= 375) begin
        if (out_m_tvalid !== 1'b1 || out_m_tlast !== (c == 375) ||
            out_m_tdata !== {8'd0, 8'd0, 16'(c - 1)}) bad_fwd++;
      end
      if (c >= 376 && c <= 400) begin
        if (out_m_tvalid !== 1'b0 || out_s_tready !== 3'b001) bad_drain++;
      end
      if (c >= 1 && c <= 400 && out_s_tready[1] !== 1'b0) bad_other++;
      if (c == 401) begin
        checks++;
        if (out_grant !== 3'b000) begin
          failures++;
          $display("FAIL trunc_idle got grant=%b want 000", out_grant);
        end
      end
      if (c == 402) begin
        checks++;
        if (out_grant !== 3'b010) begin
          failures++;
          $display("FAIL trunc_next_grant got grant=%b want 010", out_grant);
        end
      end
    end
    checks++;
    if (bad_fwd !== 0) begin
      failures++; $display("FAIL trunc_fwd_beats got %0d bad beats want 0", bad_fwd);
    end
    checks++;
    if (bad_drain !== 0) begin
      failures++; $display("FAIL trunc_drain got %0d bad cycles want 0", bad_drain);
    end
    checks++;
    if (bad_other !== 0) begin
      failures++; $display("FAIL trunc_other_ready got %0d cycles want 0", bad_other);
    end
    checks++;
    if (n_trunc !== 1 || trunc_cyc !== 376) begin
      failures++;
      $display("FAIL trunc_pulse got count=%0d at cycle %0d want 1 at 376", n_trunc, trunc_cyc);
    end
  endtask

  task automatic test_pause();
    do_reset();
    src_left[0] = 1; src_len[0] = 5;
    src_left[1] = 1; src_len[1] = 2;
    for (int c = 0; c <= 11; c++) begin
      pause = (c >= 2 && c <= 9);
      step();
      if (c >= 1 && c <= 5) begin
        checks++;
        if (out_grant !== 3'b001 || out_m_tvalid !== 1'b1 ||
            out_m_tdata !== {8'd0, 8'd0, 16'(c - 1)} || out_m_tlast !== (c == 5)) begin
          failures++;
          $display("FAIL pause_frame c=%0d got grant=%b data=%h last=%b want beat %0d",
                   c, out_grant, out_m_tdata, out_m_tlast, c - 1);
        end
      end else if (c >= 6 && c <= 10) begin
        checks++;
        if (out_grant !== 3'b000) begin
          failures++;
          $display("FAIL pause_hold c=%0d got grant=%b want 000", c, out_grant);
        end
      end else if (c == 11) begin
        checks++;
        if (out_grant !== 3'b010) begin
          failures++;
          $display("FAIL pause_resume got grant=%b want 010", out_grant);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    src_left[2] = 1; src_len[2] = 6;
    repeat (3) step();
    checks++;
    if (out_grant !== 3'b100 || out_m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got grant=%b valid=%b want 100/1", out_grant, out_m_tvalid);
    end
    #2 tx_rst = 1'b1;
    #1;
    checks++;
    if (out_grant !== 3'b000 || out_m_tvalid !== 1'b0 || out_s_tready !== 3'b000) begin
      failures++;
      $display("FAIL arst_clear got grant=%b valid=%b ready=%b want 000/0/000",
               out_grant, out_m_tvalid, out_s_tready);
    end
    do_reset();
    src_left[0] = 1; src_len[0] = 2;
    src_left[2] = 1; src_len[2] = 2;
    repeat (2) step();
    checks++;
    if (out_grant !== 3'b001) begin
      failures++;
      $display("FAIL arst_restart got grant=%b want 001", out_grant);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_grant [4] = '{3'b000, 3'b010, 3'b000, 3'b010};
    do_reset();
    src_left[1] = 2; src_len[1] = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({1'b0, out_grant} !== exp_grant[c] || out_m_tvalid !== (c % 2 == 1)) begin
        failures++;
        $display("FAIL single_req c=%0d got grant=%b valid=%b want %b", c, out_grant,
                 out_m_tvalid, exp_grant[c][2:0]);
      end
    end
  endtask

  initial begin
    clear_src();
    test_reset();
    test_round_robin();
    test_ready_toggle();
    test_truncation();
    test_pause();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/tx_axis_frame_arbiter.md
Name: tx_axis_frame_arbiter

Overview:
Frame-level round-robin arbiter that shares the single AXI-Stream payload input of the TX MAC between NUM_PORTS requesters (e.g. host DMA, control/pause generator, loopback). A grant is held for a whole frame, from the first beat through the tlast beat, so frames never interleave. It also enforces a maximum payload length, holds off new frames while flow-control pause is asserted, and exposes grant status for debug.

Parameters:
NUM_PORTS, 3, number of requesting AXIS sources (2..8)
AXIS_DATA_WIDTH, 32, tdata width per port
AXIS_DATA_BYTES, AXIS_DATA_WIDTH/8, tkeep width per port
MAX_BEATS, 375, maximum accepted beats per frame (1500-byte payload / 4)

Ports:
tx_clk  in  1  TX clock, single clock domain
tx_rst  in  1  asynchronous, active-high reset
in_s_tdata  in  NUM_PORTS*AXIS_DATA_WIDTH  flattened per-port tdata, port p at [p*W +: W]
in_s_tkeep  in  NUM_PORTS*AXIS_DATA_BYTES  flattened per-port tkeep
in_s_tvalid  in  NUM_PORTS  per-port tvalid
in_s_tlast  in  NUM_PORTS  per-port tlast
out_s_tready  out  NUM_PORTS  per-port tready
out_m_tdata  out  AXIS_DATA_WIDTH  to TX MAC slave tdata
out_m_tkeep  out  AXIS_DATA_BYTES  to TX MAC slave tkeep
out_m_tvalid  out  1  to TX MAC slave tvalid
out_m_tlast  out  1  to TX MAC slave tlast
in_m_tready  in  1  TX MAC slave tready
in_tx_pause  in  1  1 = do not start new frames
out_grant  out  NUM_PORTS  one-hot current grant, 0 when idle
out_trunc_err  out  1  one-cycle pulse when a frame is truncated

Behaviour:
- Reset (async, active-high): state IDLE, out_grant 0, rr_ptr 0, beat_cnt 0, out_s_tready 0, out_m_tvalid 0, out_m_tlast 0, out_trunc_err 0.
- States: IDLE, FWD, DRAIN.
- IDLE: if in_tx_pause=0 and any in_s_tvalid, select the first valid port searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS. Register its one-hot grant and go to FWD. Grant latency is 1 cycle: no beat is forwarded in the IDLE cycle. If pause=1, stay in IDLE.
- FWD: combinational mux. out_m_* = granted port's signals. out_s_tready[g] = in_m_tready; all other tready bits = 0.
  - Each beat accepted (valid & ready) increments beat_cnt.
  - Accepted beat with tlast=1: go to IDLE, clear the grant, beat_cnt 0, rr_ptr = (g+1) mod NUM_PORTS.
  - Grant is held while the granted source deasserts tvalid mid-frame. There is no timeout.
- Truncation: if an accepted beat is number MAX_BEATS (beat_cnt = MAX_BEATS-1 before it) and its tlast=0, force out_m_tlast=1 on that beat, pulse out_trunc_err on the next cycle, and go to DRAIN.
- DRAIN: out_s_tready[g]=1 and out_m_tvalid=0. Discard source beats until an accepted tlast, then take the same IDLE/rr_ptr update as FWD.
- Pause: sampled only in IDLE. A frame in progress always completes. tlast and pause rising in the same cycle: frame ends, no new grant while pause is held.
- Minimum one IDLE cycle between consecutive frames, so back-to-back frames cost one bubble.
- beat_cnt width is $clog2(MAX_BEATS+1). It never wraps because it is cleared on every frame end.
- Reset mid-frame: everything clears immediately. The partial frame downstream is not repaired.
- Single requester: granted repeatedly. rr_ptr still advances, with no starvation effect.

Optional Feature:
TX_ARB_STATS_EN
- Defined: adds output out_frame_cnt, NUM_PORTS*16 bits. Per port, it counts frames completed (the tlast beat accepted in FWD or DRAIN), wraps at 16'hFFFF→0, and resets to 0. It also adds out_trunc_cnt, 16 bits, counting truncations.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

Decomposition:
- Package tx_arb_pkg: state enum (IDLE/FWD/DRAIN), default MAX_BEATS, counter width function.
- One sub-module, rr_select: combinational. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and a found flag. It is reusable by other schedulers.

Test Plan:
- Ports 0,1,2 all valid with 4-beat frames, rr_ptr=0 → frames delivered in order 0,1,2,0. out_grant sequence 001,010,100, with exactly one idle cycle between frames.
- Port 1 sends 3 beats with in_m_tready toggling 1,0,1,0,… → output data matches beat-for-beat, and ports 0/2 tready stay 0 throughout.
- Port 0 sends a 400-beat frame without tlast until beat 400 → 375 beats forwarded, with tlast on beat 375. out_trunc_err pulses once. Beats 376–400 are consumed with out_m_tvalid=0, then the next port is granted.
- in_tx_pause=1 asserted during beat 2 of a 5-beat frame → frame completes. No grant while pause=1. Grant resumes 1 cycle after pause=0.
- Assert tx_rst asynchronously mid-frame → out_grant, out_m_tvalid and out_s_tready go to 0 without a clock edge. After release, arbitration restarts from port 0.
- With TX_ARB_STATS_EN, run 70000 frames on port 2 → out_frame_cnt[2] = 70000 mod 65536 = 4464.
